// File: rtl/btn_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// btn_ctrl_fsm
//
// Button controller and arbiter for the digital clock. Four debounced button
// levels compete for a single "button resource": the first (highest-priority)
// rising edge seen while idle becomes the owner, and every other button is
// ignored until the owner is released. Each owned press is classified as
// SHORT, LONG or (for the up button only) auto-REPEAT, and the resulting
// event drives the clock mode, the stopwatch run/clear controls and the
// time-set increment pulses.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-low (sampled on rising clk)
//   i_btn_mode    debounced level, mode button      (priority 0, highest)
//   i_btn_run     debounced level, run/stop button  (priority 1)
//   i_btn_clr     debounced level, clear button     (priority 2)
//   i_btn_up      debounced level, increment button (priority 3, lowest)
//   o_mode        0=CLOCK, 1=STOPWATCH, 2=SET_HOUR, 3=SET_MIN
//   o_sw_run      stopwatch run enable (level)
//   o_sw_clear    stopwatch clear, 1-clk pulse
//   o_inc_hour    hour increment, 1-clk pulse
//   o_inc_min     minute increment, 1-clk pulse
//   o_set_active  high in SET_HOUR / SET_MIN
//
// Parameters:
//   TICK_DIV   clk cycles per 1 ms tick
//   LONG_MS    hold time (ms ticks) that turns a press into a LONG event
//   REPEAT_MS  auto-repeat period (ms ticks) after a LONG press of "up"
// ---------------------------------------------------------------------------
module btn_ctrl_fsm #(
    parameter int TICK_DIV  = 100000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_run,
    input  logic       i_btn_clr,
    input  logic       i_btn_up,
    output logic [1:0] o_mode,
    output logic       o_sw_run,
    output logic       o_sw_clear,
    output logic       o_inc_hour,
    output logic       o_inc_min,
    output logic       o_set_active
);

    // -----------------------------------------------------------------------
    // Local constants
    // -----------------------------------------------------------------------
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXC = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int HW   = $clog2(MAXC + 1);

    // Button indices; lower index means higher arbitration priority.
    localparam logic [1:0] BTN_MODE = 2'd0;
    localparam logic [1:0] BTN_RUN  = 2'd1;
    localparam logic [1:0] BTN_CLR  = 2'd2;
    localparam logic [1:0] BTN_UP   = 2'd3;

    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_SW    = 2'd1;
    localparam logic [1:0] MODE_SETH  = 2'd2;
    localparam logic [1:0] MODE_SETM  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_SHORT  = 2'd1,
        EV_LONG   = 2'd2,
        EV_REPEAT = 2'd3
    } event_t;

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    logic [3:0]    btn_lvl;
    logic [3:0]    prev_q;
    logic [3:0]    rise;

    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          tick;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    owner_q;
    logic [1:0]    owner_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          owner_lvl;

    logic          cap_valid;
    logic [1:0]    cap_idx;
    event_t        ev;

    logic [1:0]    mode_q;
    logic [1:0]    mode_d;
    logic          run_q;
    logic          run_d;
    logic          clear_q;
    logic          clear_d;
    logic          inc_hour_q;
    logic          inc_hour_d;
    logic          inc_min_q;
    logic          inc_min_d;

    assign btn_lvl = {i_btn_up, i_btn_clr, i_btn_run, i_btn_mode};

    // -----------------------------------------------------------------------
    // Per-button rising-edge detection
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            assign rise[gi] = btn_lvl[gi] & ~prev_q[gi];
        end
    endgenerate

    // The previous-level register resets to all ones so that a button that
    // is already held when reset is released does not look like a new press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= 4'hF;
        end else begin
            prev_q <= btn_lvl;
        end
    end

    // -----------------------------------------------------------------------
    // Free-running 1 ms tick. Press timing counts ticks, not clocks, so a
    // press duration is only resolved to within one tick.
    // -----------------------------------------------------------------------
    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Priority capture: scanning from lowest to highest priority lets the
    // highest-priority rising button overwrite the others.
    // -----------------------------------------------------------------------
    always_comb begin
        cap_valid = 1'b0;
        cap_idx   = BTN_MODE;
        for (int i = 3; i >= 0; i--) begin
            if (rise[i]) begin
                cap_valid = 1'b1;
                cap_idx   = 2'(i);
            end
        end
    end

    assign owner_lvl = btn_lvl[owner_q];

    // -----------------------------------------------------------------------
    // Press classification FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= BTN_MODE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        ev      = EV_NONE;
        case (state_q)
            ST_IDLE: begin
                // Rises on other buttons while busy are simply never looked
                // at, which is what makes them dropped rather than queued.
                if (cap_valid) begin
                    owner_d = cap_idx;
                    hold_d  = '0;
                    state_d = ST_PRESS;
                end
            end
            ST_PRESS: begin
                // Release is tested first so that a release coinciding with
                // the LONG threshold still yields a SHORT event.
                if (!owner_lvl) begin
                    ev      = EV_SHORT;
                    state_d = ST_IDLE;
                end else if (hold_q == HW'(LONG_MS)) begin
                    ev      = EV_LONG;
                    hold_d  = '0;
                    state_d = ST_HOLD;
                end else if (tick) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_HOLD: begin
                if (!owner_lvl) begin
                    state_d = ST_IDLE;
                end else if (owner_q == BTN_UP) begin
                    if (hold_q == HW'(REPEAT_MS)) begin
                        ev     = EV_REPEAT;
                        hold_d = '0;
                    end else if (tick) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Event to control mapping. All effects are registered, so an event
    // decided in one cycle shows up on the outputs in the next, and the
    // pulse registers fall back to zero one cycle later.
    // -----------------------------------------------------------------------
    always_comb begin
        mode_d     = mode_q;
        run_d      = run_q;
        clear_d    = 1'b0;
        inc_hour_d = 1'b0;
        inc_min_d  = 1'b0;
        if (ev != EV_NONE) begin
            case (owner_q)
                BTN_MODE: begin
                    if (ev == EV_SHORT) begin
                        // CLOCK<->STOPWATCH and SET_HOUR<->SET_MIN both
                        // differ only in the low mode bit.
                        mode_d = {mode_q[1], ~mode_q[0]};
                    end else if (ev == EV_LONG) begin
                        if (mode_q == MODE_CLOCK) begin
                            mode_d = MODE_SETH;
                        end else if (mode_q[1]) begin
                            mode_d = MODE_CLOCK;
                        end
                    end
                end
                BTN_RUN: begin
                    if (ev == EV_SHORT && mode_q == MODE_SW) begin
                        run_d = ~run_q;
                    end
                end
                BTN_CLR: begin
                    if (mode_q == MODE_SW) begin
                        if (ev == EV_SHORT && !run_q) begin
                            clear_d = 1'b1;
                        end else if (ev == EV_LONG) begin
                            // Long clear stops and clears even while running.
                            run_d   = 1'b0;
                            clear_d = 1'b1;
                        end
                    end
                end
                BTN_UP: begin
                    if (mode_q == MODE_SETH) begin
                        inc_hour_d = 1'b1;
                    end else if (mode_q == MODE_SETM) begin
                        inc_min_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q     <= MODE_CLOCK;
            run_q      <= 1'b0;
            clear_q    <= 1'b0;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            run_q      <= run_d;
            clear_q    <= clear_d;
            inc_hour_q <= inc_hour_d;
            inc_min_q  <= inc_min_d;
        end
    end

    assign o_mode       = mode_q;
    assign o_sw_run     = run_q;
    assign o_sw_clear   = clear_q;
    assign o_inc_hour   = inc_hour_q;
    assign o_inc_min    = inc_min_q;
    assign o_set_active = mode_q[1];

endmodule

// File: doc/btn_ctrl_fsm.md
Name: btn_ctrl_fsm

Overview:
Button controller and arbiter for the digital clock. It takes four debounced button levels and grants the button resource to one of them at a time. It classifies each press as short, long or auto-repeat, then sequences the clock mode and the stopwatch and time-set controls. It sits between the per-button debouncers (level outputs) and the clock/stopwatch counters.

Parameters:
TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clk)
LONG_MS, 1000, hold time in ms that classifies a press as long
REPEAT_MS, 200, auto-repeat period in ms after a long press (up button only)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low: the block resets when rst is sampled 0 on a rising clk edge
i_btn_mode  input  1  debounced level, mode button
i_btn_run  input  1  debounced level, run/stop button
i_btn_clr  input  1  debounced level, clear button
i_btn_up  input  1  debounced level, increment button
o_mode  output  2  0=CLOCK, 1=STOPWATCH, 2=SET_HOUR, 3=SET_MIN
o_sw_run  output  1  stopwatch run enable (level)
o_sw_clear  output  1  stopwatch clear, 1-clk pulse
o_inc_hour  output  1  hour increment, 1-clk pulse
o_inc_min  output  1  minute increment, 1-clk pulse
o_set_active  output  1  high when o_mode is 2 or 3 (decoded from the o_mode register)

Behaviour:
- Reset (rst==0 at posedge):
  - o_mode=0, o_sw_run=0, all pulses 0.
  - FSM=IDLE, tick and hold counters 0.
  - Previous-level registers set to all 1s, so a button held through reset must be released before it can be captured.
- Tick: free-running counter 0..TICK_DIV-1; a 1-clk tick is generated at wrap. Hold timing therefore has ±1 ms resolution.
- Edge detect: rise = level & ~prev_level, evaluated per button every clk.
- Arbitration:
  - In IDLE, capture the highest-priority button with a rise in that cycle. Priority: mode > run > clr > up.
  - Store it as owner, clear the hold counter, go to PRESS.
  - Rises on non-owner buttons outside IDLE are dropped, never queued.
  - Simultaneous rises: only the highest-priority button is captured; the others must be re-pressed.
- FSM:
  - IDLE -> PRESS on capture.
  - PRESS: hold counter increments per tick.
    - Owner level 0 before the counter reaches LONG_MS: SHORT event, -> IDLE.
    - Counter == LONG_MS with owner still 1: LONG event, clear the counter, -> HOLD.
  - HOLD:
    - If owner is up: a REPEAT event each time the counter reaches REPEAT_MS, then the counter is cleared.
    - Owner level 0 -> IDLE, no event.
- Event latency: an event decided in cycle N drives its output effect (pulse high or register change) in cycle N+1. Pulses are exactly 1 clk wide.
- Event mapping:
  - mode SHORT: CLOCK<->STOPWATCH; SET_HOUR<->SET_MIN.
  - mode LONG:
    - CLOCK -> SET_HOUR.
    - SET_HOUR or SET_MIN -> CLOCK.
    - STOPWATCH: ignored.
  - run SHORT: toggle o_sw_run only when o_mode=1; otherwise ignored.
  - clr SHORT: when o_mode=1 and o_sw_run=0, pulse o_sw_clear; ignored while running or in other modes.
  - clr LONG: when o_mode=1, o_sw_run<=0 and pulse o_sw_clear in the same cycle.
  - up SHORT/LONG/REPEAT: pulse o_inc_hour in SET_HOUR, o_inc_min in SET_MIN; ignored in other modes.
- Leaving STOPWATCH does not change o_sw_run; the stopwatch keeps running in the background.
- Reset mid-press: FSM returns to IDLE, no event or pulse is emitted, and the owner must be released and re-pressed.
- Owner released in the same cycle the counter hits LONG_MS: release wins, SHORT event.

Test Plan:
(Bench uses TICK_DIV=10, LONG_MS=5, REPEAT_MS=2.)
- Reset with mode held, release rst, keep mode high 100 clk -> o_mode stays 0, no pulses. Release then press 20 clk -> o_mode=1 one clk after release.
- o_mode=1, press run 20 clk -> o_sw_run=1. Press clr 20 clk -> no o_sw_clear. Press run again -> o_sw_run=0. Press clr -> exactly one o_sw_clear pulse.
- o_mode=1, o_sw_run=1, hold clr 80 clk -> o_sw_run=0 and one o_sw_clear pulse at ~50 clk; nothing on release.
- From CLOCK, hold mode 60 clk -> o_mode=2, o_set_active=1. Short mode -> o_mode=3. Hold up 150 clk -> one o_inc_min at ~50 clk, then one every 20 clk (total 6 pulses).
- Press run and up in the same clk while o_mode=1 -> only run honoured (o_sw_run toggles). Press clr while run is held -> dropped.
- Assert rst at 30 clk into a mode press -> no pulses, o_mode=0. After release, re-press required to act.
